// File: rtl/barrel_shift_pipe_if.sv
// Operand-issue and result-writeback handshake bundle for barrel_shift_pipe.
// master = producer/consumer side, slave = the shifter.
interface barrel_shift_pipe_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
);
    logic                   IVALID;
    logic                   IREADY;
    logic [DATA_WIDTH-1:0]  IDATA;
    logic [SHAMT_WIDTH-1:0] SHAMT;
    logic                   DIR;
    logic                   ARITH;
    logic                   OVALID;
    logic                   OREADY;
    logic [DATA_WIDTH-1:0]  ODATA;

    modport master (
        output IVALID, IDATA, SHAMT, DIR, ARITH, OREADY,
        input  IREADY, OVALID, ODATA
    );

    modport slave (
        input  IVALID, IDATA, SHAMT, DIR, ARITH, OREADY,
        output IREADY, OVALID, ODATA
    );
endinterface

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter, one 2^k stage + register slice per SHAMT bit; latency SHAMT_WIDTH cycles.
// Backpressure: global stall, every slice holds and IREADY drops while OVALID && !OREADY.
module barrel_shift_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic               CLK,
    input  logic               RST,
    barrel_shift_pipe_if.slave io
);
    localparam int NS = SHAMT_WIDTH;
    localparam int SW = (NS > 1) ? NS - 1 : 1;
    localparam int RT = (NS > 1) ? (NS * (NS - 1)) / 2 : 1;

    logic                  vld    [NS];
    logic [DATA_WIDTH-1:0] dat    [NS];
    logic                  dir_q  [SW];
    logic                  fill_q [SW];
    // Remaining shift bits, packed triangularly: slice k keeps NS-1-k bits at offset OFF(k).
    logic [RT-1:0]         rem_q;
    logic                  advance;

    assign advance   = ~vld[NS-1] | io.OREADY;
    assign io.IREADY = advance;
    assign io.OVALID = vld[NS-1];
    assign io.ODATA  = dat[NS-1];

    for (genvar k = 0; k < NS; k++) begin : g_stage
        localparam int SH = 1 << k;

        logic                  in_vld;
        logic                  in_dir;
        logic                  in_fill;
        logic                  in_bit;
        logic [DATA_WIDTH-1:0] in_dat;
        logic [DATA_WIDTH-1:0] shifted;
        logic [DATA_WIDTH-1:0] stage_out;

        if (k == 0) begin : g_head
            assign in_vld  = io.IVALID;
            assign in_dat  = io.IDATA;
            assign in_dir  = io.DIR;
            assign in_fill = io.ARITH & io.IDATA[DATA_WIDTH-1];
            assign in_bit  = io.SHAMT[0];
        end else begin : g_body
            localparam int PO = (k - 1) * (NS - 1) - ((k - 1) * (k - 2)) / 2;
            assign in_vld  = vld[k-1];
            assign in_dat  = dat[k-1];
            assign in_dir  = dir_q[k-1];
            assign in_fill = fill_q[k-1];
            assign in_bit  = rem_q[PO];
        end

        assign shifted = in_dir ? (in_dat << SH)
                                : ((in_dat >> SH) |
                                   ({DATA_WIDTH{in_fill}} & ~({DATA_WIDTH{1'b1}} >> SH)));
        assign stage_out = in_bit ? shifted : in_dat;

        always_ff @(posedge CLK) begin
            if (RST) begin
                vld[k] <= 1'b0;
                dat[k] <= '0;
            end else if (advance) begin
                vld[k] <= in_vld;
                dat[k] <= stage_out;
            end
        end

        // The final slice only needs valid and data; control travels no further.
        if (k < NS - 1) begin : g_side
            localparam int OFF = k * (NS - 1) - (k * (k - 1)) / 2;
            localparam int RW  = NS - 1 - k;

            logic [RW-1:0] in_rem;

            if (k == 0) begin : g_rem_head
                assign in_rem = io.SHAMT[NS-1:1];
            end else begin : g_rem_body
                localparam int PO = (k - 1) * (NS - 1) - ((k - 1) * (k - 2)) / 2;
                assign in_rem = rem_q[PO+RW:PO+1];
            end

            always_ff @(posedge CLK) begin
                if (RST) begin
                    dir_q[k]             <= 1'b0;
                    fill_q[k]            <= 1'b0;
                    rem_q[OFF+RW-1:OFF]  <= '0;
                end else if (advance) begin
                    dir_q[k]             <= in_dir;
                    fill_q[k]            <= in_fill;
                    rem_q[OFF+RW-1:OFF]  <= in_rem;
                end
            end
        end
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Scoreboard bench for barrel_shift_pipe: directed vectors, streaming, random backpressure, mid-flight reset.
module tb_barrel_shift_pipe;
    localparam int DW = 32;
    localparam int NS = $clog2(DW);

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
        bit            chk;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    barrel_shift_pipe_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(NS)) io ();

    barrel_shift_pipe #(.DATA_WIDTH(DW), .SHAMT_WIDTH(NS)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io.slave)
    );

    exp_t          sbq [$];
    exp_t          mon_e;
    int            nvec = 0;
    int            nfail = 0;
    int            cyc = 0;
    bit            lat_mode = 1'b0;
    bit            rnd_ready = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [DW-1:0] model(logic [DW-1:0] d, int sh, bit dir, bit ar);
        if (dir)
            return d << sh;
        if (ar)
            return DW'($signed(d) >>> sh);
        return d >> sh;
    endfunction

    // Consumer side: random or always-ready, changed just after each rising edge.
    initial begin
        io.OREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            io.OREADY = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_ovalid", DW'(io.OVALID), DW'(1));
                check("hold_odata", io.ODATA, prev_data);
            end
            check("iready", DW'(io.IREADY), DW'(!(io.OVALID && !io.OREADY)));
            if (io.OVALID && io.OREADY) begin
                if (sbq.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_output: got %h, expected no result (cycle %0d)", io.ODATA, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", io.ODATA, mon_e.data);
                    if (mon_e.chk)
                        check("latency", DW'(cyc - mon_e.acc), DW'(NS - 1));
                end
            end
            prev_stall = io.OVALID && !io.OREADY;
            prev_data  = io.ODATA;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(logic [DW-1:0] d, int sh, bit dir, bit ar, logic [DW-1:0] expv);
        int   waited = 0;
        bit   acc = 1'b0;
        exp_t e;
        io.IVALID = 1'b1;
        io.IDATA  = d;
        io.SHAMT  = sh[NS-1:0];
        io.DIR    = dir;
        io.ARITH  = ar;
        while (!acc) begin
            @(negedge clk);
            if (io.IREADY) begin
                acc    = 1'b1;
                e.data = expv;
                e.acc  = cyc + 1;
                e.chk  = lat_mode;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            if (!acc) begin
                waited++;
                if (waited > 200) begin
                    nvec++;
                    nfail++;
                    $display("FAIL send_timeout: IREADY stayed %0d, expected 1 within 200 cycles", io.IREADY);
                    acc = 1'b1;
                end
            end
        end
        io.IVALID = 1'b0;
    endtask

    task automatic idle(int n);
        io.IVALID = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w = 0;
        while (sbq.size() > 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        #1;
        check("drain_left", DW'(sbq.size()), DW'(0));
    endtask

    initial begin
        logic [DW-1:0] d;
        int            sh;
        bit            dir;
        bit            ar;

        io.IVALID = 1'b0;
        io.IDATA  = '0;
        io.SHAMT  = '0;
        io.DIR    = 1'b0;
        io.ARITH  = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_ovalid", DW'(io.OVALID), DW'(0));
        check("reset_odata", io.ODATA, DW'(0));
        check("reset_iready", DW'(io.IREADY), DW'(1));
        @(posedge clk);
        #1;
        idle(6);

        // Directed vectors, consumer always ready, fixed latency checked.
        lat_mode = 1'b1;
        send(32'h8000_00F0,  4, 1'b0, 1'b0, 32'h0800_000F);
        idle(7);
        send(32'h8000_00F0, 31, 1'b0, 1'b1, 32'hFFFF_FFFF);
        send(32'h8000_00F0,  4, 1'b1, 1'b0, 32'h0000_0F00);
        send(32'h8000_00F0,  4, 1'b1, 1'b1, 32'h0000_0F00);
        send(32'h8000_00F0,  0, 1'b0, 1'b0, 32'h8000_00F0);
        send(32'h8000_00F0,  0, 1'b0, 1'b1, 32'h8000_00F0);
        send(32'h8000_00F0,  0, 1'b1, 1'b0, 32'h8000_00F0);
        send(32'h8000_00F0,  0, 1'b1, 1'b1, 32'h8000_00F0);
        send(32'h7000_0000,  4, 1'b0, 1'b1, 32'h0700_0000);
        send(32'h8000_0001,  1, 1'b0, 1'b1, 32'hC000_0000);
        send(32'h8000_0000, 31, 1'b0, 1'b0, 32'h0000_0001);
        send(32'h0000_0001, 31, 1'b1, 1'b0, 32'h8000_0000);
        send(32'h8765_4321, 16, 1'b0, 1'b1, 32'hFFFF_8765);
        send(32'h8765_4321, 16, 1'b0, 1'b0, 32'h0000_8765);
        send(32'h8765_4321,  8, 1'b1, 1'b0, 32'h6543_2100);
        drain();

        // Back-to-back streaming of random operands.
        for (int i = 0; i < 100; i++) begin
            d   = $urandom;
            sh  = $urandom_range(0, DW - 1);
            dir = 1'($urandom_range(0, 1));
            ar  = 1'($urandom_range(0, 1));
            send(d, sh, dir, ar, model(d, sh, dir, ar));
        end
        drain();

        // Random producer against a random consumer.
        lat_mode  = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                d   = $urandom;
                sh  = $urandom_range(0, DW - 1);
                dir = 1'($urandom_range(0, 1));
                ar  = 1'($urandom_range(0, 1));
                send(d, sh, dir, ar, model(d, sh, dir, ar));
            end else begin
                idle(1);
            end
        end
        drain();
        rnd_ready = 1'b0;
        idle(2);

        // Reset with three operands in flight; none of them may emerge.
        lat_mode = 1'b1;
        send(32'h1234_5678, 4, 1'b0, 1'b0, 32'h0123_4567);
        send(32'hF000_0000, 8, 1'b0, 1'b1, 32'hFFF0_0000);
        send(32'h0000_00FF, 8, 1'b1, 1'b0, 32'h0000_FF00);
        rst = 1'b1;
        sbq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_ovalid", DW'(io.OVALID), DW'(0));
        @(posedge clk);
        #1;
        idle(8);
        send(32'hA5A5_0000, 12, 1'b0, 1'b1, 32'hFFFA_5A50);
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Pipelined barrel shifter with valid/ready handshaking, built as a chain of single-bit-weighted shift stages (logical right, arithmetic right, logical left), with one register slice after every stage. Sits between the operand-issue logic and the result writeback path. It wraps the per-stage conditional shifters in a stallable pipeline so a new shift can be accepted every cycle at full clock rate.

## Interface
- DATA_WIDTH, 32: operand width; must be a power of two, ≥ 2.
- SHAMT_WIDTH, $clog2(DATA_WIDTH): shift-amount width; also the number of stages and the latency.

- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous, active-high reset.
- IVALID  input  1  input operand valid.
- IREADY  output  1  block can accept an operand this cycle.
- IDATA  input  DATA_WIDTH  operand.
- SHAMT  input  SHAMT_WIDTH  shift amount, 0..DATA_WIDTH-1.
- DIR  input  1  0 = right, 1 = left.
- ARITH  input  1  1 = sign-fill on right shift; ignored when DIR=1.
- OVALID  output  1  ODATA holds a result.
- OREADY  input  1  consumer accepts the result this cycle.
- ODATA  output  DATA_WIDTH  shifted result.

## Operation
- Stage k (k = 0..SHAMT_WIDTH-1) shifts by 2^k when its registered copy of SHAMT[k] is 1; otherwise it passes data unchanged.
- Right shift: vacated MSBs filled with fill bit; fill = IDATA[DATA_WIDTH-1] captured at acceptance when ARITH=1, else 0. Fill is carried down the pipe with the operand, not recomputed per stage.
- Left shift: vacated LSBs filled with 0.
- Each slice registers: valid, data, remaining SHAMT bits, DIR, fill bit.
- Transfer in: IVALID && IREADY. Transfer out: OVALID && OREADY.
- Global stall: advance = ~OVALID || OREADY. When advance=1 every slice loads from its predecessor (slice 0 from inputs, valid = IVALID); when 0 all slices hold.
- IREADY = advance (combinational from OVALID, OREADY). No combinational path IDATA→ODATA.
- Bubbles are not collapsed; an invalid slice still occupies its position.
- Data in invalid slices is don't-care for the consumer but must be deterministic (reset value 0, then whatever was loaded).

## Timing
- Reset: all valid bits 0, all data/SHAMT/DIR/fill registers 0; hence OVALID=0, ODATA=0, IREADY=1 in the first cycle after reset.
- Latency: operand accepted at edge n appears with OVALID=1 after edge n+SHAMT_WIDTH-1 ... i.e. exactly SHAMT_WIDTH accepting edges with no stall; each stall cycle adds one.
- Throughput: one result per cycle with OREADY held high.
- Holding: while OVALID=1 and OREADY=0, ODATA and OVALID are stable; IREADY=0; IVALID/IDATA ignored.
- Simultaneous OREADY and IVALID with full pipe: output leaves and input enters on the same edge, no bubble.
- RST mid-operation: all in-flight operands dropped; OVALID=0 on the next cycle regardless of OREADY.
- SHAMT=0: result equals operand for every DIR/ARITH combination.
- Order is strictly preserved; no operand is duplicated or lost under any OREADY pattern.

## Test plan
- Reset then idle: after RST high for 2 cycles → OVALID=0, ODATA=0, IREADY=1; OVALID stays 0 with IVALID=0.
- Logical right: IDATA=0x8000_00F0, SHAMT=4, DIR=0, ARITH=0 → ODATA=0x0800_000F exactly 5 cycles later (DATA_WIDTH=32).
- Arithmetic right and left: IDATA=0x8000_00F0, SHAMT=31, ARITH=1 → 0xFFFF_FFFF; same with DIR=1, SHAMT=4 → 0x0000_0F00; SHAMT=0 any mode → 0x8000_00F0.
- Back-to-back streaming: 100 random operands, IVALID and OREADY always 1 → 100 results, one per cycle, in order, matching reference model.
- Backpressure: random OREADY (50%) and random IVALID → ODATA stable while OVALID&&~OREADY, no loss/duplication, IREADY low exactly when OVALID&&~OREADY.
- Reset mid-flight: three operands in flight, assert RST one cycle → OVALID=0 next cycle, none of the three emerge; a fresh operand afterwards returns correct result at normal latency.
